id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the R/I/J MIPS-subset CPU. It sits directly downstream of the fetch stage and captures that stage's instruction word and PC+4 into an IF/ID pipeline register. The captured word is decoded into register indices, an extended immediate, branch and jump targets, and control signals for the execute stage. The block supports stall and flush, and traps on illegal opcodes until the pipeline is redirected.

## Interface
Parameters:
- `ALU_OP_W`, 4, width of ALU operation code.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_inst`  in  32  instruction word from fetch.
- `if_pc4`  in  32  fetch PC+4.
- `if_valid`  in  1  fetch word is meaningful this cycle.
- `stall`  in  1  hold the IF/ID register and all outputs.
- `flush`  in  1  discard the held instruction (branch or jump redirect).
- `id_valid`  out  1  outputs describe a real instruction.
- `id_pc4`  out  32  captured PC+4.
- `id_rs`, `id_rt`, `id_wreg`  out  5 each  source and destination register indices.
- `id_shamt`  out  5  shift amount.
- `id_imm`  out  32  extended immediate.
- `id_br_target`  out  32  `id_pc4 + (sext(imm16) << 2)`, modulo 2^32.
- `id_j_target`  out  32  `{id_pc4[31:28], inst[25:0], 2'b00}`.
- `id_alu_op`  out  ALU_OP_W  ALU operation.
- `id_alu_src`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  out  1 each  datapath controls.
- `id_beq`, `id_bne`, `id_jump`, `id_jal`, `id_jr`  out  1 each  control-flow class.
- `id_trap`  out  1  illegal instruction held; block is in TRAP.

## Operation
- States:
  - **EMPTY**: nothing held.
  - **HOLD**: a valid instruction is held.
  - **TRAP**: an illegal opcode or funct has been captured.
- Update priority each edge: reset > flush > stall > load.
- Reset or flush:
  - Go to EMPTY.
  - Captured word becomes `32'h0`; `id_pc4` becomes 0.
  - Every output becomes 0.
- Stall: state and all outputs are unchanged. Stall in TRAP is also a hold.
- Load:
  - Applies with no stall or flush, in EMPTY or HOLD.
  - If `if_valid=0`, go to EMPTY.
  - Otherwise capture `if_inst` and `if_pc4`.
  - Go to HOLD if the word decodes legally; otherwise go to TRAP.
- TRAP:
  - Ignores new fetch words.
  - Only flush or reset leaves it.
  - `id_valid=0`, `id_trap=1`, all controls 0.
- Supported R-type (op 0x00), by funct:
  - sll 0x00, srl 0x02, sra 0x03
  - jr 0x08
  - add 0x20, addu 0x21, sub 0x22, subu 0x23
  - and 0x24, or 0x25, xor 0x26, nor 0x27
  - slt 0x2A, sltu 0x2B
- Supported I-type, by op:
  - beq 0x04, bne 0x05
  - addi 0x08, addiu 0x09
  - slti 0x0A, sltiu 0x0B
  - andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F
  - lw 0x23, sw 0x2B
- Supported J-type, by op: j 0x02, jal 0x03.
- Anything else is illegal.
- Immediate:
  - andi, ori, xori: zero-extended.
  - lui: `{imm16,16'h0}`.
  - All others: sign-extended.
- Destination register (`id_wreg`):
  - R-type: rd.
  - I-type: rt.
  - jal: 31.
- Write enable:
  - `id_reg_write` is forced to 0 when `id_wreg==0`.
  - The all-zero NOP is therefore legal, valid, and writes nothing.
- Control fields are derived only from the held word; they are never derived from live fetch inputs.

## Timing
- Decode latency is 1 cycle: a word present at rising edge N is presented on the outputs after edge N.
- All outputs are registered; there is no combinational path from the `if_*` inputs to the outputs.
- Fetch updates its PC on the falling edge. Its `if_inst` and `if_pc4` are therefore stable at this block's rising edge.
- Flush and stall asserted together: flush wins.
- Reset deassertion is asynchronous in assertion only. The first load occurs at the first rising edge with `rst=1`.
- Reset mid-TRAP or mid-HOLD: outputs are zero immediately, without waiting for a clock edge.
- `id_br_target` wraps: pc4 `32'hFFFF_FFFC` with imm `16'h0001` gives `32'h0000_0000`.

## Structure
- Shared package holds:
  - opcode and funct constants;
  - ALU_OP encodings (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI);
  - the state encoding (EMPTY, HOLD, TRAP).
- One combinational sub-module, `inst_decode`:
  - input: a 32-bit word;
  - outputs: controls, `illegal`, and extended immediate.
- `id_stage` owns the IF/ID register, the state machine, and the target adders.

## Test plan
- Reset then load `32'h2128_FFFF` (addi $8,$9,-1) with pc4 `32'h0000_0010`:
  - `id_wreg=8`, `id_imm=32'hFFFF_FFFF`;
  - `id_alu_src=1`, `id_reg_write=1`, `id_alu_op=ADD`.
- Load `32'h1109_0003` (beq $8,$9,+3) at pc4 `32'h0000_0020`:
  - `id_beq=1`, `id_br_target=32'h0000_002C`, `id_reg_write=0`.
- Load `32'h0C00_0040` (jal) at pc4 `32'h4000_0004`:
  - `id_jal=1`, `id_wreg=31`, `id_j_target=32'h4000_0100`.
- Load `32'hFC00_0000`:
  - `id_trap=1`, `id_valid=0`.
  - Following valid words are ignored.
  - flush leads to EMPTY with all outputs 0.
- Load `32'h3C01_1234` (lui), then assert stall for 3 cycles while the fetch word changes:
  - outputs stay `id_imm=32'h1234_0000`.
  - Then assert stall and flush together: outputs become 0.
- Load `32'h0000_0000`: `id_valid=1`, `id_reg_write=0`. Drop `rst` asynchronously between edges: all outputs become 0 immediately.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: instruction encodings, ALU
// operation codes, state encoding and the record types moved between the
// decoder and the IF/ID register.
package id_stage_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Link register written by jal
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  // Execute-stage controls produced by the decoder
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    jal;
    logic    jr;
  } ctrl_t;

  // Everything the stage presents downstream, held as one register
  typedef struct packed {
    logic        valid;
    logic        trap;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [31:0] br_target;
    logic [31:0] j_target;
    ctrl_t       ctrl;
  } id_out_t;

  // Word-aligned, sign-extended branch displacement
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/id_stage_inst_decode.sv
// Pure combinational decoder: splits an instruction word into register
// indices, extended immediate and execute-stage controls, and flags words
// outside the supported subset.
module inst_decode
  import id_stage_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  shamt_o,
  output logic [4:0]  wreg_o,
  output logic [31:0] imm_o,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign op      = inst_i[31:26];
  assign funct   = inst_i[5:0];
  assign rd      = inst_i[15:11];
  assign imm16   = inst_i[15:0];
  assign rs_o    = inst_i[25:21];
  assign rt_o    = inst_i[20:16];
  assign shamt_o = inst_i[10:6];

  // Opcode/funct to controls, destination and immediate
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_ADD;
    wreg_o        = inst_i[20:16];
    imm_o         = {{16{imm16[15]}}, imm16};
    illegal_o     = 1'b0;

    unique case (op)
      OP_RTYPE: begin
        wreg_o           = rd;
        ctrl_o.reg_write = 1'b1;
        unique case (funct)
          FN_SLL:          ctrl_o.alu_op = ALU_SLL;
          FN_SRL:          ctrl_o.alu_op = ALU_SRL;
          FN_SRA:          ctrl_o.alu_op = ALU_SRA;
          FN_JR: begin
            ctrl_o.jr        = 1'b1;
            ctrl_o.reg_write = 1'b0;
          end
          FN_ADD, FN_ADDU: ctrl_o.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl_o.alu_op = ALU_SUB;
          FN_AND:          ctrl_o.alu_op = ALU_AND;
          FN_OR:           ctrl_o.alu_op = ALU_OR;
          FN_XOR:          ctrl_o.alu_op = ALU_XOR;
          FN_NOR:          ctrl_o.alu_op = ALU_NOR;
          FN_SLT:          ctrl_o.alu_op = ALU_SLT;
          FN_SLTU:         ctrl_o.alu_op = ALU_SLTU;
          default:         illegal_o     = 1'b1;
        endcase
      end
      OP_J: begin
        wreg_o      = '0;
        ctrl_o.jump = 1'b1;
      end
      OP_JAL: begin
        wreg_o           = REG_RA;
        ctrl_o.jal       = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.beq    = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_o.bne    = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl_o.alu_op    = (op == OP_SLTI) ? ALU_SLT : ALU_SLTU;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        imm_o            = {16'h0, imm16};
        ctrl_o.alu_op    = (op == OP_ANDI) ? ALU_AND :
                           (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LUI: begin
        imm_o            = {imm16, 16'h0};
        ctrl_o.alu_op    = ALU_LUI;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase

    // $0 is hard-wired: a write to it is no write at all
    if (wreg_o == 5'd0) ctrl_o.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register with EMPTY/HOLD/TRAP control.
// The fetch word is decoded as it is captured, so every output comes
// straight from a flop and reflects only the held instruction.
module id_stage #(
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         if_inst,
  input  logic [31:0]         if_pc4,
  input  logic                if_valid,
  input  logic                stall,
  input  logic                flush,
  output logic                id_valid,
  output logic [31:0]         id_pc4,
  output logic [4:0]          id_rs,
  output logic [4:0]          id_rt,
  output logic [4:0]          id_wreg,
  output logic [4:0]          id_shamt,
  output logic [31:0]         id_imm,
  output logic [31:0]         id_br_target,
  output logic [31:0]         id_j_target,
  output logic [ALU_OP_W-1:0] id_alu_op,
  output logic                id_alu_src,
  output logic                id_reg_write,
  output logic                id_mem_read,
  output logic                id_mem_write,
  output logic                id_mem_to_reg,
  output logic                id_beq,
  output logic                id_bne,
  output logic                id_jump,
  output logic                id_jal,
  output logic                id_jr,
  output logic                id_trap
);

  import id_stage_pkg::*;

  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_shamt;
  logic [4:0]  dec_wreg;
  logic [31:0] dec_imm;
  ctrl_t       dec_ctrl;
  logic        dec_illegal;

  state_e      state_q;
  id_out_t     out_q;
  id_out_t     load_d;

  inst_decode u_inst_decode (
    .inst_i    (if_inst),
    .rs_o      (dec_rs),
    .rt_o      (dec_rt),
    .shamt_o   (dec_shamt),
    .wreg_o    (dec_wreg),
    .imm_o     (dec_imm),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Record that a load would capture; an illegal word keeps only its PC+4
  always_comb begin
    load_d     = '0;
    load_d.pc4 = if_pc4;
    if (dec_illegal) begin
      load_d.trap = 1'b1;
    end else begin
      load_d.valid     = 1'b1;
      load_d.rs        = dec_rs;
      load_d.rt        = dec_rt;
      load_d.wreg      = dec_wreg;
      load_d.shamt     = dec_shamt;
      load_d.imm       = dec_imm;
      load_d.br_target = if_pc4 + branch_offset(if_inst[15:0]);
      load_d.j_target  = {if_pc4[31:28], if_inst[25:0], 2'b00};
      load_d.ctrl      = dec_ctrl;
    end
  end

  // State machine and IF/ID register: reset > flush > stall > load
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
    end else if (!stall && state_q != ST_TRAP) begin
      if (!if_valid) begin
        state_q <= ST_EMPTY;
        out_q   <= '0;
      end else begin
        state_q <= dec_illegal ? ST_TRAP : ST_HOLD;
        out_q   <= load_d;
      end
    end
  end

  assign id_valid      = out_q.valid;
  assign id_trap       = out_q.trap;
  assign id_pc4        = out_q.pc4;
  assign id_rs         = out_q.rs;
  assign id_rt         = out_q.rt;
  assign id_wreg       = out_q.wreg;
  assign id_shamt      = out_q.shamt;
  assign id_imm        = out_q.imm;
  assign id_br_target  = out_q.br_target;
  assign id_j_target   = out_q.j_target;
  assign id_alu_op     = ALU_OP_W'(out_q.ctrl.alu_op);
  assign id_alu_src    = out_q.ctrl.alu_src;
  assign id_reg_write  = out_q.ctrl.reg_write;
  assign id_mem_read   = out_q.ctrl.mem_read;
  assign id_mem_write  = out_q.ctrl.mem_write;
  assign id_mem_to_reg = out_q.ctrl.mem_to_reg;
  assign id_beq        = out_q.ctrl.beq;
  assign id_bne        = out_q.ctrl.bne;
  assign id_jump       = out_q.ctrl.jump;
  assign id_jal        = out_q.ctrl.jal;
  assign id_jr         = out_q.ctrl.jr;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a reference model predicts each cycle's
// outputs, the prediction is queued when stimulus is driven and compared
// once the stage has registered the word.
module tb_id_stage;

  import id_stage_pkg::*;

  localparam int ALU_OP_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         if_inst;
  logic [31:0]         if_pc4;
  logic                if_valid;
  logic                stall;
  logic                flush;
  logic                id_valid;
  logic [31:0]         id_pc4;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic [4:0]          id_wreg;
  logic [4:0]          id_shamt;
  logic [31:0]         id_imm;
  logic [31:0]         id_br_target;
  logic [31:0]         id_j_target;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_alu_src;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_mem_write;
  logic                id_mem_to_reg;
  logic                id_beq;
  logic                id_bne;
  logic                id_jump;
  logic                id_jal;
  logic                id_jr;
  logic                id_trap;

  always #5 clk = ~clk;

  id_stage #(.ALU_OP_W(ALU_OP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_inst       (if_inst),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid),
    .stall         (stall),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_pc4        (id_pc4),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_wreg       (id_wreg),
    .id_shamt      (id_shamt),
    .id_imm        (id_imm),
    .id_br_target  (id_br_target),
    .id_j_target   (id_j_target),
    .id_alu_op     (id_alu_op),
    .id_alu_src    (id_alu_src),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_mem_to_reg (id_mem_to_reg),
    .id_beq        (id_beq),
    .id_bne        (id_bne),
    .id_jump       (id_jump),
    .id_jal        (id_jal),
    .id_jr         (id_jr),
    .id_trap       (id_trap)
  );

  typedef struct packed {
    logic        valid;
    logic        trap;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [31:0] br;
    logic [31:0] jt;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        beq;
    logic        bne;
    logic        jump;
    logic        jal;
    logic        jr;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t cur;
  logic m_trap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode of one word captured with the given PC+4
  function automatic exp_t m_decode(input logic [31:0] w, input logic [31:0] p);
    exp_t       e;
    logic [5:0] op;
    logic [5:0] fn;
    logic       ok;
    e      = '0;
    op     = w[31:26];
    fn     = w[5:0];
    ok     = 1'b1;
    e.valid  = 1'b1;
    e.pc4    = p;
    e.rs     = w[25:21];
    e.rt     = w[20:16];
    e.shamt  = w[10:6];
    e.wreg   = w[20:16];
    e.imm    = {{16{w[15]}}, w[15:0]};
    e.br     = p + (e.imm << 2);
    e.jt     = {p[31:28], w[25:0], 2'b00};
    e.alu_op = ALU_ADD;
    case (op)
      6'h00: begin
        e.wreg      = w[15:11];
        e.reg_write = 1'b1;
        case (fn)
          6'h00:        e.alu_op = ALU_SLL;
          6'h02:        e.alu_op = ALU_SRL;
          6'h03:        e.alu_op = ALU_SRA;
          6'h08:        begin e.jr = 1'b1; e.reg_write = 1'b0; end
          6'h20, 6'h21: e.alu_op = ALU_ADD;
          6'h22, 6'h23: e.alu_op = ALU_SUB;
          6'h24:        e.alu_op = ALU_AND;
          6'h25:        e.alu_op = ALU_OR;
          6'h26:        e.alu_op = ALU_XOR;
          6'h27:        e.alu_op = ALU_NOR;
          6'h2A:        e.alu_op = ALU_SLT;
          6'h2B:        e.alu_op = ALU_SLTU;
          default:      ok = 1'b0;
        endcase
      end
      6'h02: begin e.wreg = 5'd0; e.jump = 1'b1; end
      6'h03: begin e.wreg = 5'd31; e.jal = 1'b1; e.reg_write = 1'b1; end
      6'h04: begin e.beq = 1'b1; e.alu_op = ALU_SUB; end
      6'h05: begin e.bne = 1'b1; e.alu_op = ALU_SUB; end
      6'h08, 6'h09: begin e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h0A: begin e.alu_op = ALU_SLT;  e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h0B: begin e.alu_op = ALU_SLTU; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h0C: begin e.alu_op = ALU_AND; e.imm = {16'h0, w[15:0]}; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h0D: begin e.alu_op = ALU_OR;  e.imm = {16'h0, w[15:0]}; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h0E: begin e.alu_op = ALU_XOR; e.imm = {16'h0, w[15:0]}; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h0F: begin e.alu_op = ALU_LUI; e.imm = {w[15:0], 16'h0}; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      6'h23: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; end
      6'h2B: begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (e.wreg == 5'd0) e.reg_write = 1'b0;
    if (!ok) begin
      e      = '0;
      e.trap = 1'b1;
      e.pc4  = p;
    end
    return e;
  endfunction

  // Pop the oldest prediction and compare every output against it
  task automatic compare(input string tag);
    exp_t e;
    check({tag, ":sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check({tag, ":valid"},      32'(id_valid),      32'(e.valid));
    check({tag, ":trap"},       32'(id_trap),       32'(e.trap));
    check({tag, ":pc4"},        id_pc4,             e.pc4);
    check({tag, ":rs"},         32'(id_rs),         32'(e.rs));
    check({tag, ":rt"},         32'(id_rt),         32'(e.rt));
    check({tag, ":wreg"},       32'(id_wreg),       32'(e.wreg));
    check({tag, ":shamt"},      32'(id_shamt),      32'(e.shamt));
    check({tag, ":imm"},        id_imm,             e.imm);
    check({tag, ":br_target"},  id_br_target,       e.br);
    check({tag, ":j_target"},   id_j_target,        e.jt);
    check({tag, ":alu_op"},     32'(id_alu_op),     32'(e.alu_op));
    check({tag, ":alu_src"},    32'(id_alu_src),    32'(e.alu_src));
    check({tag, ":reg_write"},  32'(id_reg_write),  32'(e.reg_write));
    check({tag, ":mem_read"},   32'(id_mem_read),   32'(e.mem_read));
    check({tag, ":mem_write"},  32'(id_mem_write),  32'(e.mem_write));
    check({tag, ":mem_to_reg"}, 32'(id_mem_to_reg), 32'(e.mem_to_reg));
    check({tag, ":beq"},        32'(id_beq),        32'(e.beq));
    check({tag, ":bne"},        32'(id_bne),        32'(e.bne));
    check({tag, ":jump"},       32'(id_jump),       32'(e.jump));
    check({tag, ":jal"},        32'(id_jal),        32'(e.jal));
    check({tag, ":jr"},         32'(id_jr),         32'(e.jr));
  endtask

  // Drive one cycle on the falling edge, predict, then compare after the rising edge
  task automatic step(input string tag, input logic [31:0] inst, input logic [31:0] pc4,
                      input logic v, input logic st, input logic fl);
    @(negedge clk);
    if_inst  = inst;
    if_pc4   = pc4;
    if_valid = v;
    stall    = st;
    flush    = fl;
    if (fl) begin
      cur    = '0;
      m_trap = 1'b0;
    end else if (!st && !m_trap) begin
      if (!v) begin
        cur = '0;
      end else begin
        cur    = m_decode(inst, pc4);
        m_trap = cur.trap;
      end
    end
    sb_q.push_back(cur);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    logic [31:0] w;
    rst      = 1'b1;
    if_inst  = '0;
    if_pc4   = '0;
    if_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    cur      = '0;
    m_trap   = 1'b0;

    // Reset asserted before any clock edge, then held across one edge with live fetch
    #1 rst = 1'b0;
    sb_q.push_back(cur);
    #2 compare("reset");
    @(negedge clk);
    if_inst  = 32'h2128_FFFF;
    if_pc4   = 32'h0000_0010;
    if_valid = 1'b1;
    sb_q.push_back(cur);
    @(posedge clk);
    #1 compare("reset_hold");
    rst = 1'b1;

    // addi $8,$9,-1
    step("addi", 32'h2128_FFFF, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    check("addi:wreg8",    32'(id_wreg), 32'd8);
    check("addi:imm",      id_imm, 32'hFFFF_FFFF);
    check("addi:alu_src",  32'(id_alu_src), 32'd1);
    check("addi:reg_wr",   32'(id_reg_write), 32'd1);
    check("addi:alu_add",  32'(id_alu_op), 32'(ALU_ADD));

    // beq $8,$9,+3
    step("beq", 32'h1109_0003, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
    check("beq:beq",       32'(id_beq), 32'd1);
    check("beq:target",    id_br_target, 32'h0000_002C);
    check("beq:reg_wr",    32'(id_reg_write), 32'd0);

    // jal
    step("jal", 32'h0C00_0040, 32'h4000_0004, 1'b1, 1'b0, 1'b0);
    check("jal:jal",       32'(id_jal), 32'd1);
    check("jal:wreg31",    32'(id_wreg), 32'd31);
    check("jal:target",    id_j_target, 32'h4000_0100);

    // Branch target wraps modulo 2^32
    step("br_wrap", 32'h1000_0001, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    check("br_wrap:target", id_br_target, 32'h0000_0000);

    // Assorted legal words
    step("andi",    32'h3128_8000, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    check("andi:zext", id_imm, 32'h0000_8000);
    step("lw",      32'h8D09_FFFC, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
    step("sw",      32'hAD09_0004, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
    step("add",     32'h0109_5020, 32'h0000_010C, 1'b1, 1'b0, 1'b0);
    step("addi_r0", 32'h2000_0005, 32'h0000_0110, 1'b1, 1'b0, 1'b0);
    check("addi_r0:reg_wr", 32'(id_reg_write), 32'd0);
    step("jr",      32'h03E0_0008, 32'h0000_0114, 1'b1, 1'b0, 1'b0);
    step("bubble",  32'h2128_FFFF, 32'h0000_0118, 1'b0, 1'b0, 1'b0);

    // Illegal opcode traps; fetch and stall are ignored until a flush
    step("trap",      32'hFC00_0000, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    check("trap:trap",  32'(id_trap), 32'd1);
    check("trap:valid", 32'(id_valid), 32'd0);
    step("trap_ign1", 32'h2128_FFFF, 32'h0000_0204, 1'b1, 1'b0, 1'b0);
    step("trap_ign2", 32'h0C00_0040, 32'h0000_0208, 1'b1, 1'b0, 1'b0);
    step("trap_stl",  32'h1109_0003, 32'h0000_020C, 1'b1, 1'b1, 1'b0);
    check("trap_hold:trap", 32'(id_trap), 32'd1);
    step("trap_fl",   32'h2128_FFFF, 32'h0000_0210, 1'b1, 1'b0, 1'b1);
    check("trap_fl:trap", 32'(id_trap), 32'd0);

    // Illegal R-type funct also traps
    step("bad_fn",    32'h0000_0001, 32'h0000_0300, 1'b1, 1'b0, 1'b0);
    step("bad_fn_fl", 32'h0000_0000, 32'h0000_0304, 1'b1, 1'b0, 1'b1);

    // lui held through three stalls while fetch changes, then stall+flush
    step("lui",   32'h3C01_1234, 32'h0000_0400, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("lui_stall", 32'h2128_0000 + 32'(i), 32'h0000_0404 + 32'(4 * i), 1'b1, 1'b1, 1'b0);
      check("lui_stall:imm", id_imm, 32'h1234_0000);
    end
    step("stall_flush", 32'h2128_FFFF, 32'h0000_0410, 1'b1, 1'b1, 1'b1);
    check("stall_flush:valid", 32'(id_valid), 32'd0);

    // NOP is valid but writes nothing; reset mid-cycle clears at once
    step("nop", 32'h0000_0000, 32'h0000_0500, 1'b1, 1'b0, 1'b0);
    check("nop:valid",  32'(id_valid), 32'd1);
    check("nop:reg_wr", 32'(id_reg_write), 32'd0);
    #2 rst = 1'b0;
    cur    = '0;
    m_trap = 1'b0;
    sb_q.push_back(cur);
    #1 compare("async_rst");
    rst = 1'b1;

    // Random words, with stalls sprinkled in and a flush whenever trapped
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if (i % 2 == 0) w[31:26] = (i % 4 == 0) ? 6'h00 : 6'($urandom_range(0, 15));
      step("rand", w, $urandom & 32'hFFFF_FFFC, 1'b1, ($urandom_range(0, 4) == 0), 1'b0);
      if (m_trap) step("rand_fl", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
